// File: rtl/pipe_types_pkg.sv
// rtl/pipe_types_pkg.sv - shared types and constants for the MIPS pipeline-stage registers
package pipe_types_pkg;

  // Occupancy of one elastic stage: nothing held, main register only, main plus skid.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } pipe_state_t;

  // Source selected for the main (output) register on the next edge.
  typedef enum logic [1:0] {
    SEL_HOLD = 2'd0,
    SEL_IN   = 2'd1,
    SEL_SKID = 2'd2,
    SEL_NOP  = 2'd3
  } main_sel_t;

  // IF/ID boundary bundle.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
  } ifid_t;

  // ID/EX boundary bundle.
  typedef struct packed {
    logic [31:0] pc_plus4;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [3:0]  alu_op;
    logic        alu_src;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        mem_to_reg;
  } idex_t;

  // EX/MEM boundary bundle.
  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] store_val;
    logic [4:0]  rd;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        mem_to_reg;
  } exmem_t;

  // MEM/WB boundary bundle.
  typedef struct packed {
    logic [31:0] wb_val;
    logic [4:0]  rd;
    logic        reg_write;
  } memwb_t;

  // Bundle widths used as WIDTH when each boundary register is instantiated.
  localparam int IFID_W  = $bits(ifid_t);
  localparam int IDEX_W  = $bits(idex_t);
  localparam int EXMEM_W = $bits(exmem_t);
  localparam int MEMWB_W = $bits(memwb_t);

  // Bubbles: all-zero instruction is sll $0,$0,0 and all write/mem enables are off.
  localparam ifid_t  IFID_NOP  = '0;
  localparam idex_t  IDEX_NOP  = '0;
  localparam exmem_t EXMEM_NOP = '0;
  localparam memwb_t MEMWB_NOP = '0;

endpackage

// File: rtl/pipe_skid_ctrl.sv
// rtl/pipe_skid_ctrl.sv - occupancy FSM, in_ready and load-select generation for one stage
module pipe_skid_ctrl
  import pipe_types_pkg::*;
#(
  parameter int SKID = 1
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      in_valid,
  input  logic      in_halt,
  input  logic      flush,
  input  logic      out_ready,
  input  logic      out_halt,
  output logic      in_ready,
  output logic      out_valid,
  output main_sel_t main_sel,
  output logic      skid_load,
  output logic      skid_clr,
  output logic      halted
);

  pipe_state_t state_q, state_d;
  logic        halt_seen_q, halt_seen_d;
  logic        halted_q, halted_d;
  logic        accept;
  logic        pop;

  assign out_valid = (state_q != EMPTY);
  assign halted    = halted_q;

  // Next occupancy, datapath load selects and halt tracking; flush overrides any transfer.
  always_comb begin
    accept      = in_valid & in_ready & ~flush;
    pop         = out_valid & out_ready & ~flush;
    state_d     = state_q;
    main_sel    = SEL_HOLD;
    skid_load   = 1'b0;
    skid_clr    = 1'b0;
    halt_seen_d = halt_seen_q;
    halted_d    = halted_q;

    if (flush) begin
      state_d  = EMPTY;
      main_sel = SEL_NOP;
      skid_clr = 1'b1;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d  = ONE;
            main_sel = SEL_IN;
          end
        end
        ONE: begin
          if (accept && pop) begin
            main_sel = SEL_IN;
          end else if (accept) begin
            // Only reachable with a skid entry; the stall register never accepts while held.
            if (SKID != 0) begin
              state_d   = FULL;
              skid_load = 1'b1;
            end
          end else if (pop) begin
            state_d  = EMPTY;
            main_sel = SEL_NOP;
          end
        end
        FULL: begin
          if (pop) begin
            state_d  = ONE;
            main_sel = SEL_SKID;
            skid_clr = 1'b1;
          end
        end
        default: begin
          state_d  = EMPTY;
          main_sel = SEL_NOP;
          skid_clr = 1'b1;
        end
      endcase
    end

    // Once the halt word has left the stage, a flush can no longer re-open the input.
    if (accept && in_halt) begin
      halt_seen_d = 1'b1;
    end else if (flush && !halted_q) begin
      halt_seen_d = 1'b0;
    end

    if (pop && out_halt) begin
      halted_d = 1'b1;
    end
  end

  // Occupancy and halt flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      halt_seen_q <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      halt_seen_q <= halt_seen_d;
      halted_q    <= halted_d;
    end
  end

  generate
    if (SKID != 0) begin : g_reg_ready
      logic in_ready_q, in_ready_d;

      // Ready is computed from next state so out_ready never reaches in_ready combinationally.
      always_comb begin
        in_ready_d = (state_d != FULL) & ~halt_seen_d & ~halted_d;
      end

      // Registered ready; comes out of reset able to accept.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          in_ready_q <= 1'b1;
        end else begin
          in_ready_q <= in_ready_d;
        end
      end

      assign in_ready = in_ready_q;
    end else begin : g_comb_ready
      assign in_ready = (~out_valid | out_ready) & ~halt_seen_q & ~halted_q;
    end
  endgenerate

endmodule

// File: rtl/elastic_pipe_reg.sv
// rtl/elastic_pipe_reg.sv - elastic pipeline-stage register with flush bubble and sticky halt
module elastic_pipe_reg
  import pipe_types_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] NOP_VALUE = '0,
  parameter int               SKID      = 1
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_halt,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_halt,
  output logic             halted
);

  logic [WIDTH-1:0] main_data_q, main_data_d;
  logic             main_halt_q, main_halt_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             skid_halt_q, skid_halt_d;
  main_sel_t        main_sel;
  logic             skid_load;
  logic             skid_clr;

  pipe_skid_ctrl #(
    .SKID (SKID)
  ) u_ctrl (
    .clk       (CLK),
    .rst_n     (nRST),
    .in_valid  (in_valid),
    .in_halt   (in_halt),
    .flush     (flush),
    .out_ready (out_ready),
    .out_halt  (main_halt_q),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .main_sel  (main_sel),
    .skid_load (skid_load),
    .skid_clr  (skid_clr),
    .halted    (halted)
  );

  assign out_data = main_data_q;
  assign out_halt = main_halt_q;

  // Steer the main and skid registers from the controller's load selects.
  always_comb begin
    main_data_d = main_data_q;
    main_halt_d = main_halt_q;
    skid_data_d = skid_data_q;
    skid_halt_d = skid_halt_q;

    case (main_sel)
      SEL_IN: begin
        main_data_d = in_data;
        main_halt_d = in_halt;
      end
      SEL_SKID: begin
        main_data_d = skid_data_q;
        main_halt_d = skid_halt_q;
      end
      SEL_NOP: begin
        main_data_d = NOP_VALUE;
        main_halt_d = 1'b0;
      end
      default: begin
        main_data_d = main_data_q;
        main_halt_d = main_halt_q;
      end
    endcase

    if (skid_clr) begin
      skid_data_d = NOP_VALUE;
      skid_halt_d = 1'b0;
    end else if (skid_load) begin
      skid_data_d = in_data;
      skid_halt_d = in_halt;
    end
  end

  // Datapath registers; reset discards any held words and shows the bubble.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      main_data_q <= NOP_VALUE;
      main_halt_q <= 1'b0;
      skid_data_q <= NOP_VALUE;
      skid_halt_q <= 1'b0;
    end else begin
      main_data_q <= main_data_d;
      main_halt_q <= main_halt_d;
      skid_data_q <= skid_data_d;
      skid_halt_q <= skid_halt_d;
    end
  end

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// tb/tb_elastic_pipe_reg.sv - scoreboard bench for skid and stall builds of elastic_pipe_reg
module tb_elastic_pipe_reg;

  localparam logic [31:0] NOP = 32'hFFFF_0000;

  logic        clk;
  logic        nrst;
  integer      checks;
  integer      failures;

  logic        v1, r1, h1, f1, ov1, or1, oh1, hd1;
  logic [31:0] d1, od1;
  logic        v0, r0, h0, f0, ov0, or0, oh0, hd0;
  logic [31:0] d0, od0;

  logic [31:0] sb1[$];
  logic [31:0] sb0[$];

  elastic_pipe_reg #(.WIDTH(32), .NOP_VALUE(NOP), .SKID(1)) u_dut (
    .CLK(clk), .nRST(nrst), .in_valid(v1), .in_ready(r1), .in_data(d1), .in_halt(h1),
    .flush(f1), .out_valid(ov1), .out_ready(or1), .out_data(od1), .out_halt(oh1), .halted(hd1)
  );

  elastic_pipe_reg #(.WIDTH(32), .NOP_VALUE(NOP), .SKID(0)) u_dut0 (
    .CLK(clk), .nRST(nrst), .in_valid(v0), .in_ready(r0), .in_data(d0), .in_halt(h0),
    .flush(f0), .out_valid(ov0), .out_ready(or0), .out_data(od0), .out_halt(oh0), .halted(hd0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    v1 = 1'b1; d1 = 32'hDEADBEEF; h1 = 1'b0; f1 = 1'b0; or1 = 1'b0;
    v0 = 1'b1; d0 = 32'hDEADBEEF; h0 = 1'b0; f0 = 1'b0; or0 = 1'b0;
    repeat (3) tick();
    checks++; if (ov1 !== 1'b0) begin failures++; $display("FAIL rst_ov1 got=%0h exp=0", ov1); end
    checks++; if (od1 !== NOP) begin failures++; $display("FAIL rst_od1 got=%h exp=%h", od1, NOP); end
    checks++; if (oh1 !== 1'b0 || hd1 !== 1'b0) begin failures++; $display("FAIL rst_halt1 got=%0b%0b exp=00", oh1, hd1); end
    checks++; if (ov0 !== 1'b0) begin failures++; $display("FAIL rst_ov0 got=%0h exp=0", ov0); end
    checks++; if (od0 !== NOP) begin failures++; $display("FAIL rst_od0 got=%h exp=%h", od0, NOP); end
    v1 = 1'b0; v0 = 1'b0;
    nrst = 1'b1;
    tick();
    checks++; if (r1 !== 1'b1) begin failures++; $display("FAIL rst_rdy1 got=%0h exp=1", r1); end
    checks++; if (r0 !== 1'b1) begin failures++; $display("FAIL rst_rdy0 got=%0h exp=1", r0); end
    checks++; if (ov1 !== 1'b0) begin failures++; $display("FAIL rst_ov1_post got=%0h exp=0", ov1); end
  endtask

  task automatic test_streaming();
    int pops;
    logic [31:0] exp;
    pops = 0;
    or1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      v1 = (i < 3);
      d1 = 32'(i + 1);
      #1;
      checks++; if (r1 !== 1'b1) begin failures++; $display("FAIL stream_rdy c%0d got=%0h exp=1", i, r1); end
      checks++; if (ov1 !== (i >= 1 && i <= 3)) begin failures++; $display("FAIL stream_ov c%0d got=%0h exp=%0h", i, ov1, (i >= 1 && i <= 3)); end
      if (ov1 && or1) begin
        pops++;
        exp = (sb1.size() > 0) ? sb1.pop_front() : 32'hXXXX_XXXX;
        checks++; if (od1 !== exp) begin failures++; $display("FAIL stream_data c%0d got=%h exp=%h", i, od1, exp); end
      end
      if (v1 && r1) sb1.push_back(d1);
      tick();
    end
    v1 = 1'b0;
    checks++; if (pops != 3 || sb1.size() != 0) begin failures++; $display("FAIL stream_pops got=%0d left=%0d exp=3 left=0", pops, sb1.size()); end
  endtask

  task automatic test_backpressure();
    int pops;
    logic [31:0] exp;
    pops = 0;
    or1 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      v1 = 1'b1;
      d1 = (i == 0) ? 32'hA : 32'hB;
      #1;
      checks++; if (r1 !== 1'b1) begin failures++; $display("FAIL bp_rdy_fill c%0d got=%0h exp=1", i, r1); end
      if (v1 && r1) sb1.push_back(d1);
      tick();
    end
    v1 = 1'b0;
    #1;
    checks++; if (r1 !== 1'b0) begin failures++; $display("FAIL bp_rdy_full got=%0h exp=0", r1); end
    checks++; if (ov1 !== 1'b1 || od1 !== 32'hA) begin failures++; $display("FAIL bp_head got=%0h/%h exp=1/%h", ov1, od1, 32'hA); end
    tick();
    or1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (ov1 && or1) begin
        pops++;
        exp = (sb1.size() > 0) ? sb1.pop_front() : 32'hXXXX_XXXX;
        checks++; if (od1 !== exp) begin failures++; $display("FAIL bp_data c%0d got=%h exp=%h", i, od1, exp); end
      end
      tick();
    end
    checks++; if (pops != 2 || sb1.size() != 0) begin failures++; $display("FAIL bp_pops got=%0d left=%0d exp=2 left=0", pops, sb1.size()); end
  endtask

  task automatic test_flush();
    or1 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      v1 = 1'b1;
      d1 = (i == 0) ? 32'hA : 32'hB;
      #1;
      if (v1 && r1) sb1.push_back(d1);
      tick();
    end
    f1 = 1'b1; v1 = 1'b1; d1 = 32'hC;
    sb1.delete();
    tick();
    f1 = 1'b0; v1 = 1'b0;
    #1;
    checks++; if (ov1 !== 1'b0) begin failures++; $display("FAIL flush_ov got=%0h exp=0", ov1); end
    checks++; if (od1 !== NOP) begin failures++; $display("FAIL flush_od got=%h exp=%h", od1, NOP); end
    checks++; if (oh1 !== 1'b0) begin failures++; $display("FAIL flush_oh got=%0h exp=0", oh1); end
    checks++; if (r1 !== 1'b1) begin failures++; $display("FAIL flush_rdy got=%0h exp=1", r1); end
    f1 = 1'b1; v1 = 1'b1; d1 = 32'hC;
    tick();
    f1 = 1'b0; v1 = 1'b0; or1 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (ov1 !== 1'b0) begin failures++; $display("FAIL flush_drop c%0d got=%0h/%h exp=0", i, ov1, od1); end
      tick();
    end
  endtask

  task automatic test_halt();
    or1 = 1'b0;
    v1 = 1'b1; d1 = 32'h5; h1 = 1'b1;
    #1;
    checks++; if (r1 !== 1'b1) begin failures++; $display("FAIL halt_rdy0 got=%0h exp=1", r1); end
    if (v1 && r1) sb1.push_back(d1);
    tick();
    v1 = 1'b1; d1 = 32'h6; h1 = 1'b0;
    #1;
    checks++; if (r1 !== 1'b0) begin failures++; $display("FAIL halt_rdy1 got=%0h exp=0", r1); end
    checks++; if (ov1 !== 1'b1 || od1 !== 32'h5 || oh1 !== 1'b1) begin failures++; $display("FAIL halt_word got=%0h/%h/%0h exp=1/5/1", ov1, od1, oh1); end
    checks++; if (hd1 !== 1'b0) begin failures++; $display("FAIL halt_early got=%0h exp=0", hd1); end
    tick();
    or1 = 1'b1;
    #1;
    checks++; if (r1 !== 1'b0) begin failures++; $display("FAIL halt_rdy2 got=%0h exp=0", r1); end
    if (ov1 && or1 && sb1.size() > 0) begin
      checks++; if (od1 !== sb1.pop_front()) begin failures++; $display("FAIL halt_pop got=%h exp=5", od1); end
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (hd1 !== 1'b1) begin failures++; $display("FAIL halt_sticky c%0d got=%0h exp=1", i, hd1); end
      checks++; if (ov1 !== 1'b0 || r1 !== 1'b0) begin failures++; $display("FAIL halt_blocked c%0d got=%0h/%0h exp=0/0", i, ov1, r1); end
      f1 = (i == 1);
      tick();
    end
    f1 = 1'b0; v1 = 1'b0;
  endtask

  task automatic test_skid0();
    logic [31:0] exp;
    or0 = 1'b0; v0 = 1'b1; d0 = 32'h11; h0 = 1'b0; f0 = 1'b0;
    #1;
    checks++; if (r0 !== 1'b1) begin failures++; $display("FAIL s0_rdy_empty got=%0h exp=1", r0); end
    if (v0 && r0) sb0.push_back(d0);
    tick();
    d0 = 32'h22;
    #1;
    checks++; if (ov0 !== 1'b1 || od0 !== 32'h11) begin failures++; $display("FAIL s0_head got=%0h/%h exp=1/11", ov0, od0); end
    checks++; if (r0 !== 1'b0) begin failures++; $display("FAIL s0_rdy_stall got=%0h exp=0", r0); end
    or0 = 1'b1;
    #1;
    checks++; if (r0 !== 1'b1) begin failures++; $display("FAIL s0_rdy_pass got=%0h exp=1", r0); end
    if (ov0 && or0) begin
      exp = (sb0.size() > 0) ? sb0.pop_front() : 32'hXXXX_XXXX;
      checks++; if (od0 !== exp) begin failures++; $display("FAIL s0_data1 got=%h exp=%h", od0, exp); end
    end
    if (v0 && r0) sb0.push_back(d0);
    tick();
    v0 = 1'b0;
    #1;
    checks++; if (ov0 !== 1'b1) begin failures++; $display("FAIL s0_ov2 got=%0h exp=1", ov0); end
    if (ov0 && or0) begin
      exp = (sb0.size() > 0) ? sb0.pop_front() : 32'hXXXX_XXXX;
      checks++; if (od0 !== exp) begin failures++; $display("FAIL s0_data2 got=%h exp=%h", od0, exp); end
    end
    tick();
    v0 = 1'b1; f0 = 1'b1; d0 = 32'h33; or0 = 1'b0;
    #1;
    checks++; if (ov0 !== 1'b0 || od0 !== NOP) begin failures++; $display("FAIL s0_drain got=%0h/%h exp=0/%h", ov0, od0, NOP); end
    tick();
    v0 = 1'b0; f0 = 1'b0;
    #1;
    checks++; if (ov0 !== 1'b0 || od0 !== NOP) begin failures++; $display("FAIL s0_flush_drop got=%0h/%h exp=0/%h", ov0, od0, NOP); end
    checks++; if (sb0.size() != 0) begin failures++; $display("FAIL s0_left got=%0d exp=0", sb0.size()); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_halt();
    test_skid0();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/elastic_pipe_reg.md
Name: elastic_pipe_reg

Overview:
Parametrised, elastic pipeline-stage register for the five-stage MIPS datapath. It generalises the fixed ID/EX latch to any bundle width with a valid/ready handshake, a synchronous flush that injects a NOP bubble, and sticky halt tracking. It can be built as a simple stall register or as a two-entry skid buffer with a registered ready. One instance sits between each pair of pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB), with the stage bundle packed into a single vector.

Parameters:
WIDTH, 32, width of the packed stage bundle carried in data.
NOP_VALUE, '0, WIDTH-bit value driven on out_data when empty, after flush, or in reset.
SKID, 1, 0 = simple stall register (ready passes through combinationally); 1 = two-entry skid buffer (registered in_ready, full throughput).

Ports:
CLK  input  1  clock; all state changes on the rising edge.
nRST  input  1  asynchronous active-low reset.
in_valid  input  1  upstream stage presents a word.
in_ready  output  1  stage can accept a word this cycle.
in_data  input  WIDTH  upstream bundle.
in_halt  input  1  upstream word is a halt instruction.
flush  input  1  squash every word held in the stage.
out_valid  output  1  out_data holds a valid word.
out_ready  input  1  downstream stage accepts the word.
out_data  output  WIDTH  registered bundle.
out_halt  output  1  halt flag travelling with out_data.
halted  output  1  sticky: a halt word has left this stage.

Behaviour:
- Reset (nRST low, asynchronous): out_valid=0, out_data=NOP_VALUE, out_halt=0, halted=0, skid entry empty, halt_seen=0; in_ready=1 once reset deasserts (registered value 1 in SKID=1).
- Handshake: accept = in_valid & in_ready; pop = out_valid & out_ready. Data, valid and halt move together. Latency from in to out is 1 cycle. in_data must hold while in_valid=1 and in_ready=0.
- SKID=0:
  - in_ready = (~out_valid | out_ready) & ~halt_seen, combinational.
  - On accept: out_data <= in_data, out_valid <= 1.
  - On pop without accept: out_valid <= 0, out_data <= NOP_VALUE.
- SKID=1, states EMPTY/ONE/FULL; the main register drives out_*, the skid register holds the overflow word:
  - EMPTY: accept -> ONE (main <= in).
  - ONE: accept & ~pop -> FULL (skid <= in). accept & pop -> ONE (main <= in). pop & ~accept -> EMPTY (main <= NOP_VALUE).
  - FULL: in_ready=0. pop -> ONE (main <= skid, skid cleared).
  - in_ready is registered: ~(next state FULL) & ~next halt_seen. There is no combinational path from out_ready to in_ready.
- Flush:
  - Synchronous. Has priority over accept and pop in the same cycle.
  - Next state: EMPTY, out_valid=0, out_data=NOP_VALUE, out_halt=0, skid cleared.
  - A word presented the same cycle is dropped, with no accept side effects.
- Halt:
  - An accepted word with in_halt=1 sets halt_seen, and in_ready stays 0 until reset.
  - flush clears halt_seen only if halted=0.
  - pop with out_halt=1 sets halted, which is sticky until reset; in_ready stays 0.
- Simultaneous accept and pop in ONE sustains 1 word/cycle.
- out_ready is ignored when out_valid=0.
- Reset asserted mid-transfer discards all held words immediately.

Decomposition:
- Shared package pipe_types_pkg:
  - typedef pipe_state_t (EMPTY, ONE, FULL).
  - Per-boundary packed struct typedefs (ifid_t, idex_t, exmem_t, memwb_t), each with its $bits used as WIDTH at instantiation.
  - NOP constants for each boundary.
- One sub-module, pipe_skid_ctrl: the state machine and in_ready/load-select generation, parametrised only by SKID. The datapath registers stay in elastic_pipe_reg.

Test Plan:
- Reset: hold nRST=0 with in_valid=1, in_data=32'hDEADBEEF -> out_valid=0, out_data=NOP_VALUE; 1 cycle after release in_ready=1.
- Streaming, SKID=1: out_ready=1, push 32'h1, 32'h2, 32'h3 on consecutive cycles -> each appears 1 cycle later, in_ready never drops, 3 pops in 3 cycles.
- Backpressure: push 32'hA, then 32'hB, with out_ready=0 -> state FULL, in_ready=0 the next cycle. Raise out_ready -> pops A then B in order, no loss, no duplication.
- Flush while FULL (A, B held), with in_valid=1 and 32'hC in the same cycle -> next cycle out_valid=0, out_data=NOP_VALUE; C is never output.
- Halt: push 32'h5 with in_halt=1, then offer 32'h6 -> 6 is never accepted (in_ready=0). When 5 pops, out_halt=1 and halted=1 from the next cycle and stays set.
- SKID=0: out_ready=0 with out_valid=1 -> in_ready=0 in the same cycle. out_ready=1 with in_valid=1 -> accept and pop in one cycle.
